// File: rtl/debug_pkg.sv
// Shared encodings for the debug sequencer: command opcodes, FSM states and the default fetch state.
package debug_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_MEM_RD = 3'd1,
    OP_MEM_WR = 3'd2,
    OP_REG_RD = 3'd3,
    OP_REG_WR = 3'd4,
    OP_RUN    = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_ACC  = 3'd1,
    S_REG_ACC  = 3'd2,
    S_REG_HOLD = 3'd3,
    S_RUN_RST  = 3'd4,
    S_RUN_EXEC = 3'd5,
    S_RESP     = 3'd6
  } state_e;

  localparam logic [8:0] FETCH_STATE_DEF = 9'd1;

endpackage

// File: rtl/fetch_counter.sv
// Counts rising edges of the CPU entering its fetch state while enabled; done_o flags,
// combinationally, the cycle in which the count reaches the target.
module fetch_counter
  import debug_pkg::*;
#(
  parameter logic [8:0] FETCH_STATE = FETCH_STATE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [8:0]  state_i,
  input  logic [16:0] target_i,
  output logic        done_o
);

  logic        is_fetch;
  logic        prev_q;
  logic [16:0] cnt_q;
  logic [16:0] cnt_d;

  assign is_fetch = (state_i == FETCH_STATE);
  assign cnt_d    = cnt_q + {16'd0, en_i & is_fetch & ~prev_q};
  assign done_o   = en_i & (cnt_d == target_i);

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q  <= 17'd0;
      prev_q <= 1'b0;
    end else if (en_i) begin
      cnt_q  <= cnt_d;
      prev_q <= is_fetch;
    end
  end

endmodule

// File: rtl/debug_sequencer.sv
// Debug command sequencer: takes valid/ready commands and drives the SystemTest debug inputs
// for memory/register access and bounded instruction runs, returning one response per command.
module debug_sequencer
  import debug_pkg::*;
#(
  parameter int         ACCESS_CYCLES = 2,
  parameter logic [8:0] FETCH_STATE   = FETCH_STATE_DEF,
  parameter int         RUN_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        test,
  output logic        memoryoperation,
  output logic        memorywrite,
  output logic        registeroperation,
  output logic        registerwrite,
  output logic        cpu_reset,
  output logic [15:0] memaddress,
  output logic [15:0] memwritedata,
  output logic [15:0] regwritedata,
  output logic [15:0] resetpc,
  output logic [3:0]  registeraddress,
  input  logic [15:0] MD,
  input  logic [15:0] RD,
  input  logic [15:0] PC,
  input  logic [8:0]  state
);

  localparam logic [7:0]  ACC_LAST = 8'(ACCESS_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(RUN_TIMEOUT - 1);

  state_e      state_q;
  logic [15:0] data_q;
  logic [7:0]  acc_q;
  logic [15:0] cyc_q;
  logic [16:0] target;
  logic        fetch_done;

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  // Stop at the start of fetch N+1 so the Nth instruction has fully retired.
  assign target    = {1'b0, data_q} + 17'd1;

  fetch_counter #(
    .FETCH_STATE(FETCH_STATE)
  ) u_fetch_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == S_RUN_RST),
    .en_i    (state_q == S_RUN_EXEC),
    .state_i (state),
    .target_i(target),
    .done_o  (fetch_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      data_q            <= 16'd0;
      acc_q             <= 8'd0;
      cyc_q             <= 16'd0;
      rsp_data          <= 16'd0;
      rsp_err           <= 1'b0;
      test              <= 1'b0;
      memoryoperation   <= 1'b0;
      memorywrite       <= 1'b0;
      registeroperation <= 1'b0;
      registerwrite     <= 1'b0;
      cpu_reset         <= 1'b0;
      memaddress        <= 16'd0;
      memwritedata      <= 16'd0;
      regwritedata      <= 16'd0;
      resetpc           <= 16'd0;
      registeraddress   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          data_q   <= cmd_data;
          acc_q    <= 8'd0;
          cyc_q    <= 16'd0;
          rsp_data <= 16'd0;
          rsp_err  <= 1'b0;
          case (cmd_op)
            OP_NOP: state_q <= S_RESP;
            OP_MEM_RD, OP_MEM_WR: begin
              memoryoperation <= 1'b1;
              memaddress      <= cmd_addr;
              memorywrite     <= (cmd_op == OP_MEM_WR);
              memwritedata    <= (cmd_op == OP_MEM_WR) ? cmd_data : 16'd0;
              state_q         <= S_MEM_ACC;
            end
            OP_REG_RD, OP_REG_WR: begin
              registeroperation <= 1'b1;
              registeraddress   <= cmd_addr[3:0];
              registerwrite     <= (cmd_op == OP_REG_WR);
              regwritedata      <= (cmd_op == OP_REG_WR) ? cmd_data : 16'd0;
              state_q           <= S_REG_ACC;
            end
            OP_RUN: begin
              if (cmd_data == 16'd0) begin
                rsp_err <= 1'b1;
                state_q <= S_RESP;
              end else begin
                cpu_reset <= 1'b1;
                resetpc   <= cmd_addr;
                state_q   <= S_RUN_RST;
              end
            end
            default: begin
              rsp_err <= 1'b1;
              state_q <= S_RESP;
            end
          endcase
        end
        S_MEM_ACC: begin
          acc_q <= acc_q + 8'd1;
          if (acc_q == ACC_LAST) begin
            rsp_data        <= MD;
            rsp_err         <= memorywrite && (MD != data_q);
            memoryoperation <= 1'b0;
            memorywrite     <= 1'b0;
            state_q         <= S_RESP;
          end
        end
        S_REG_ACC: begin
          acc_q <= acc_q + 8'd1;
          if (acc_q == ACC_LAST) begin
            rsp_data <= RD;
            rsp_err  <= registerwrite && (RD != data_q);
            if (registerwrite) begin
              state_q <= S_REG_HOLD;
            end else begin
              registeroperation <= 1'b0;
              state_q           <= S_RESP;
            end
          end
        end
        S_REG_HOLD: begin
          registeroperation <= 1'b0;
          registerwrite     <= 1'b0;
          state_q           <= S_RESP;
        end
        S_RUN_RST: begin
          cpu_reset <= 1'b0;
          test      <= 1'b1;
          state_q   <= S_RUN_EXEC;
        end
        S_RUN_EXEC: begin
          cyc_q <= cyc_q + 16'd1;
          if (fetch_done || cyc_q == TMO_LAST) begin
            test     <= 1'b0;
            rsp_data <= PC;
            rsp_err  <= !fetch_done;
            state_q  <= S_RESP;
          end
        end
        S_RESP: if (rsp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_sequencer.sv
// Directed bench for debug_sequencer with a small memory/register-file/CPU model standing in for SystemTest.
module tb_debug_sequencer;

  localparam logic [2:0] OP_NOP = 3'd0, OP_MRD = 3'd1, OP_MWR = 3'd2,
                         OP_RRD = 3'd3, OP_RWR = 3'd4, OP_RUN = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_addr = 16'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        test, memoryoperation, memorywrite, registeroperation, registerwrite, cpu_reset;
  logic [15:0] memaddress, memwritedata, regwritedata, resetpc;
  logic [3:0]  registeraddress;
  logic [15:0] MD, RD, PC;
  logic [8:0]  state;

  logic [15:0] mem [0:65535];
  logic [15:0] regs [0:15];
  logic [15:0] cpu_pc = 16'd0;
  logic [15:0] cpu_ir = 16'd0;
  logic [8:0]  cpu_st = 9'd2;

  int errors = 0;
  int checks = 0;
  int rw_cnt = 0;
  int crst_cnt = 0;
  int excl_bad = 0;

  always #5 clk = ~clk;

  debug_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .test(test), .memoryoperation(memoryoperation), .memorywrite(memorywrite),
    .registeroperation(registeroperation), .registerwrite(registerwrite), .cpu_reset(cpu_reset),
    .memaddress(memaddress), .memwritedata(memwritedata), .regwritedata(regwritedata),
    .resetpc(resetpc), .registeraddress(registeraddress),
    .MD(MD), .RD(RD), .PC(PC), .state(state)
  );

  assign MD    = mem[memaddress];
  assign RD    = regs[registeraddress];
  assign PC    = cpu_pc;
  assign state = cpu_st;

  always @(posedge clk) begin
    if (memoryoperation && memorywrite) mem[memaddress] <= memwritedata;
  end

  // CPU model: state 1 = fetch, state 2 = execute. 1xxx jr rN, 2000 jal <next word> (r14 = link), Fxxx hang.
  always @(posedge clk) begin
    if (registeroperation && registerwrite) regs[registeraddress] <= regwritedata;
    if (cpu_reset) begin
      cpu_pc <= resetpc;
      cpu_st <= 9'd1;
    end else if (test) begin
      if (cpu_st == 9'd1) begin
        cpu_ir <= mem[cpu_pc];
        cpu_pc <= cpu_pc + 16'd1;
        cpu_st <= 9'd2;
      end else begin
        case (cpu_ir[15:12])
          4'h1: begin cpu_pc <= regs[cpu_ir[3:0]]; cpu_st <= 9'd1; end
          4'h2: begin regs[14] <= cpu_pc + 16'd1; cpu_pc <= mem[cpu_pc]; cpu_st <= 9'd1; end
          4'hF: cpu_st <= 9'd2;
          default: cpu_st <= 9'd1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (registerwrite) rw_cnt++;
    if (cpu_reset) crst_cnt++;
    if ((test && memoryoperation) || (test && registeroperation) ||
        (memoryoperation && registeroperation) || (cpu_reset && test)) excl_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                       output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 6000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_wait", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic err, output int lat);
    issue(op, a, d, lat);
    rd  = rsp_data;
    err = rsp_err;
    accept();
  endtask

  initial begin
    logic [15:0] rd;
    logic        err;
    int          lat;
    int          snap;
    int          seen;

    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    for (int i = 0; i < 16; i++) regs[i] = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ctrl", {26'd0, test, memoryoperation, memorywrite, registeroperation, registerwrite, cpu_reset}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    do_cmd(OP_MWR, 16'd3, 16'hEE02, rd, err, lat);
    chk("mwr_data", {16'd0, rd}, 32'hEE02);
    chk("mwr_err", {31'd0, err}, 32'd0);
    chk("mwr_lat", lat, 32'd3);
    do_cmd(OP_MRD, 16'd3, 16'h0000, rd, err, lat);
    chk("mrd_data", {16'd0, rd}, 32'hEE02);
    chk("mrd_err", {31'd0, err}, 32'd0);
    chk("mrd_lat", lat, 32'd3);

    snap = rw_cnt;
    do_cmd(OP_RWR, 16'd0, 16'd11, rd, err, lat);
    chk("rwr_data", {16'd0, rd}, 32'd11);
    chk("rwr_lat", lat, 32'd4);
    chk("rwr_pulse_len", rw_cnt - snap, 32'd3);
    do_cmd(OP_RRD, 16'd0, 16'd0, rd, err, lat);
    chk("rrd_data", {16'd0, rd}, 32'd11);
    chk("rrd_lat", lat, 32'd3);

    do_cmd(OP_NOP, 16'd0, 16'd0, rd, err, lat);
    chk("nop_err", {31'd0, err}, 32'd0);
    chk("nop_lat", lat, 32'd1);
    do_cmd(3'd7, 16'd0, 16'd0, rd, err, lat);
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_lat", lat, 32'd1);

    do_cmd(OP_MWR, 16'd3, 16'h1000, rd, err, lat);
    snap = crst_cnt;
    do_cmd(OP_RUN, 16'd3, 16'd1, rd, err, lat);
    chk("run_jr_pc", {16'd0, rd}, 32'd11);
    chk("run_jr_err", {31'd0, err}, 32'd0);
    chk("run_jr_test_after", {31'd0, test}, 32'd0);
    chk("run_jr_cpu_reset_len", crst_cnt - snap, 32'd1);

    do_cmd(OP_MWR, 16'd3, 16'h2000, rd, err, lat);
    do_cmd(OP_MWR, 16'd4, 16'h800F, rd, err, lat);
    do_cmd(OP_RUN, 16'd3, 16'd1, rd, err, lat);
    chk("run_jal_pc", {16'd0, rd}, 32'h800F);
    chk("run_jal_err", {31'd0, err}, 32'd0);
    do_cmd(OP_RRD, 16'd14, 16'd0, rd, err, lat);
    chk("jal_link_r14", {16'd0, rd}, 32'd5);

    snap = crst_cnt;
    do_cmd(OP_RUN, 16'd3, 16'd0, rd, err, lat);
    chk("run0_err", {31'd0, err}, 32'd1);
    chk("run0_lat", lat, 32'd1);
    chk("run0_no_cpu_reset", crst_cnt - snap, 32'd0);

    do_cmd(OP_MWR, 16'd3, 16'hF000, rd, err, lat);
    do_cmd(OP_RUN, 16'd3, 16'd1, rd, err, lat);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_pc", {16'd0, rd}, 32'd4);
    chk("tmo_lat", lat, 32'd4098);
    chk("tmo_test_after", {31'd0, test}, 32'd0);

    issue(OP_MRD, 16'd3, 16'd0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", {16'd0, rsp_data}, 32'hF000);
      chk("hold_err", {31'd0, rsp_err}, 32'd0);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    accept();

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_MRD;
    cmd_addr  = 16'd3;
    cmd_data  = 16'd0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("abort_memop_started", {31'd0, memoryoperation}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ctrl_zero", {24'd0, test, memoryoperation, memorywrite, registeroperation,
                            registerwrite, cpu_reset, rsp_valid, cmd_ready}, 32'd0);
    chk("abort_addr_zero", {16'd0, memaddress}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 32'd0);
    do_cmd(OP_RRD, 16'd0, 16'd0, rd, err, lat);
    chk("post_abort_rrd", {16'd0, rd}, 32'd11);

    chk("exclusivity", excl_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
